uart_boot_loader: RTL and testbench

- Serial program loader upstream of the pipelined RV32I core; fills instruction memory (BRAM port A) from a UART byte stream, then releases the core from reset.
- While cpu_rst_n is low, the top muxes BRAM port A (wea/addra/dia) to this block; after release, port A reverts to IF fetch.
- Contains a UART receiver plus a framing FSM: sync, length, data, checksum.

---
 rtl/uart_boot_loader_pkg.sv | 19 +
 rtl/uart_boot_loader_uart_rx.sv | 96 +++++++++
 rtl/uart_boot_loader.sv | 145 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_loader_pkg.sv
// Shared constants for the UART boot loader: framing bytes, write strobe and FSM encoding.
package uart_boot_loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [3:0] WORD_WE   = 4'hF;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;
    localparam logic [2:0] ST_ERR  = 3'd5;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_boot_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling with a down-counter,
// one-cycle rx_valid or frame_err per frame.
module uart_rx
    import uart_boot_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    logic [2:0]    r_sync;
    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_shift;
    logic          w_rx;
    logic          w_fall;

    // r_sync[2] is the previous synchronised sample, used for edge detection
    assign w_rx   = r_sync[1];
    assign w_fall = r_sync[2] & ~r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= 3'b111;
        else        r_sync <= {r_sync[1:0], rx_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            rx_valid  <= 1'b0;
            rx_byte   <= '0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (r_state)
                RX_IDLE: begin
                    if (w_fall) begin
                        r_state <= RX_START;
                        r_cnt   <= HALF_LOAD;
                    end
                end
                RX_START: begin
                    if (r_cnt == '0) begin
                        if (w_rx) begin
                            r_state <= RX_IDLE;
                        end else begin
                            r_state   <= RX_DATA;
                            r_cnt     <= FULL_LOAD;
                            r_bit_cnt <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift   <= {w_rx, r_shift[7:1]};
                        r_cnt     <= FULL_LOAD;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) r_state <= RX_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (r_cnt == '0) begin
                        r_state <= RX_IDLE;
                        if (w_rx) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= r_shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Serial program loader: receives a framed image over UART, writes it into
// instruction memory word by word, then releases the core from reset.
//
// state | meaning
// IDLE  | waiting for sync byte, other bytes ignored
// LEN   | collecting 4-byte little-endian word count
// DATA  | assembling words, writing each to memory, summing bytes
// CSUM  | comparing the final byte against the running checksum
// DONE  | image accepted, core released, input ignored until reset
// ERR   | load failed, waiting for a new sync byte
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100000000,
    parameter int BAUD        = 115200,
    parameter int MAX_WORDS   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx_i,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di,
    output logic        cpu_rst_n,
    output logic        load_done,
    output logic        load_err,
    output logic        busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD;
    localparam int IW           = $clog2(MAX_WORDS) + 1;

    logic          w_rx_valid;
    logic [7:0]    w_rx_byte;
    logic          w_frame_err;

    logic [2:0]    r_state;
    logic [1:0]    r_byte_cnt;
    logic [23:0]   r_len;
    logic [23:0]   r_word;
    logic [IW-1:0] r_count;
    logic [IW-1:0] r_index;
    logic [7:0]    r_csum;
    logic [3:0]    r_mem_we;
    logic [31:0]   r_mem_addr;
    logic [31:0]   r_mem_di;

    logic [31:0]   w_len_full;
    logic [31:0]   w_word_full;
    logic [IW-1:0] w_index_next;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_i     (uart_rx_i),
        .rx_valid (w_rx_valid),
        .rx_byte  (w_rx_byte),
        .frame_err(w_frame_err)
    );

    // Little-endian: each new byte lands on top, earlier bytes shift down
    assign w_len_full   = {w_rx_byte, r_len};
    assign w_word_full  = {w_rx_byte, r_word};
    assign w_index_next = r_index + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_byte_cnt <= '0;
            r_len      <= '0;
            r_word     <= '0;
            r_count    <= '0;
            r_index    <= '0;
            r_csum     <= '0;
            r_mem_we   <= '0;
            r_mem_addr <= '0;
            r_mem_di   <= '0;
        end else begin
            r_mem_we <= '0;
            case (r_state)
                ST_IDLE, ST_ERR: begin
                    if (w_rx_valid && w_rx_byte == SYNC_BYTE) begin
                        r_state    <= ST_LEN;
                        r_byte_cnt <= '0;
                        r_index    <= '0;
                        r_csum     <= '0;
                    end
                end
                ST_LEN: begin
                    if (w_frame_err) begin
                        r_state <= ST_ERR;
                    end else if (w_rx_valid) begin
                        r_len      <= w_len_full[31:8];
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            if (w_len_full > 32'(MAX_WORDS)) begin
                                r_state <= ST_ERR;
                            end else if (w_len_full == 32'd0) begin
                                r_state <= ST_CSUM;
                            end else begin
                                r_count <= w_len_full[IW-1:0];
                                r_state <= ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (w_frame_err) begin
                        r_state <= ST_ERR;
                    end else if (w_rx_valid) begin
                        r_csum     <= r_csum + w_rx_byte;
                        r_word     <= w_word_full[31:8];
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_we   <= WORD_WE;
                            r_mem_addr <= 32'(r_index) << 2;
                            r_mem_di   <= w_word_full;
                            r_index    <= w_index_next;
                            if (w_index_next == r_count) r_state <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (w_frame_err) begin
                        r_state <= ST_ERR;
                    end else if (w_rx_valid) begin
                        r_state <= (w_rx_byte == r_csum) ? ST_DONE : ST_ERR;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_di    = r_mem_di;
    assign cpu_rst_n = (r_state == ST_DONE);
    assign load_done = (r_state == ST_DONE);
    assign load_err  = (r_state == ST_ERR);
    assign busy      = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_CSUM);

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: a byte-stream parser model predicts writes and
// final flags; a per-cycle monitor checks every write pulse and held address/data.
module tb_uart_boot_loader;

    localparam int CPB       = 16;
    localparam int MAX_WORDS = 4096;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        uart_rx_i = 1'b1;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_di;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;
    logic        busy;

    int          n_checks = 0;
    int          n_pass = 0;
    int          n_writes = 0;
    wr_t         exp_q[$];
    logic [31:0] exp_last_addr = '0;
    logic [31:0] exp_last_data = '0;
    logic [31:0] dut_last_addr = '0;
    logic [31:0] dut_last_data = '0;
    logic        prev_we_hi = 1'b0;
    // 0 idle, 1 loading, 2 done, 3 error
    int          model_state = 0;

    uart_boot_loader #(
        .CLK_FREQ_HZ(1600000),
        .BAUD       (100000),
        .MAX_WORDS  (MAX_WORDS)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .uart_rx_i(uart_rx_i),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_di   (mem_di),
        .cpu_rst_n(cpu_rst_n),
        .load_done(load_done),
        .load_err (load_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_last_addr = '0;
            exp_last_data = '0;
            prev_we_hi    = 1'b0;
        end else begin
            if (mem_we == 4'hF) begin
                wr_t w;
                check("we_single_cycle", {31'd0, prev_we_hi}, 32'd0);
                dut_last_addr = mem_addr;
                dut_last_data = mem_di;
                n_writes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {28'd0, mem_we}, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("write_addr", mem_addr, w.addr);
                    check("write_data", mem_di, w.data);
                    exp_last_addr = w.addr;
                    exp_last_data = w.data;
                end
            end else begin
                check("we_idle", {28'd0, mem_we}, 32'd0);
                check("addr_hold", mem_addr, exp_last_addr);
                check("data_hold", mem_di, exp_last_data);
            end
            prev_we_hi = (mem_we == 4'hF);
        end
    end

    // Parse a byte stream the way the loader protocol defines it; bad = index of the
    // byte sent with a broken stop bit (-1 for none).
    task automatic model_stream(input bq_t s, input int bad);
        int          j;
        int          c;
        logic [31:0] n;
        logic [7:0]  cs;
        wr_t         w;
        if (model_state == 2) return;
        j = -1;
        if (model_state != 1) begin
            for (int k = 0; k < s.size(); k++) begin
                if (s[k] == 8'hA5 && k != bad) begin
                    j = k;
                    break;
                end
            end
            if (j < 0) return;
            model_state = 1;
        end
        if (bad > j && bad <= j + 4) begin
            model_state = 3;
            return;
        end
        if (s.size() < j + 5) return;
        n = {s[j+4], s[j+3], s[j+2], s[j+1]};
        if (n > MAX_WORDS) begin
            model_state = 3;
            return;
        end
        cs = 8'd0;
        for (int wi = 0; wi < int'(n); wi++) begin
            for (int b = 0; b < 4; b++) begin
                int idx = j + 5 + 4 * wi + b;
                if (idx == bad) begin
                    model_state = 3;
                    return;
                end
                if (idx >= s.size()) return;
                cs = cs + s[idx];
                w.data[8*b +: 8] = s[idx];
            end
            w.addr = 32'(wi) * 32'd4;
            exp_q.push_back(w);
        end
        c = j + 5 + 4 * int'(n);
        if (c == bad) begin
            model_state = 3;
            return;
        end
        if (c >= s.size()) return;
        model_state = (s[c] == cs) ? 2 : 3;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx_i = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = b[i];
            wait_clks(CPB);
        end
        uart_rx_i = stop;
        wait_clks(CPB);
        uart_rx_i = 1'b1;
        wait_clks(CPB);
    endtask

    task automatic check_outcome(input string name);
        check({name, "_busy"}, {31'd0, busy}, {31'd0, model_state == 1});
        check({name, "_done"}, {31'd0, load_done}, {31'd0, model_state == 2});
        check({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, model_state == 2});
        check({name, "_err"}, {31'd0, load_err}, {31'd0, model_state == 3});
        check({name, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_stream(input string name, input bq_t s, input int bad, input bit check_sync);
        model_stream(s, bad);
        for (int k = 0; k < s.size(); k++) begin
            send_byte(s[k], k != bad);
            if (check_sync && k == 0) begin
                check({name, "_sync_clears_err"}, {31'd0, load_err}, 32'd0);
                check({name, "_sync_busy"}, {31'd0, busy}, 32'd1);
            end
        end
        wait_clks(4);
        check_outcome(name);
    endtask

    task automatic check_reset_values(input string name);
        check({name, "_we"}, {28'd0, mem_we}, 32'd0);
        check({name, "_addr"}, mem_addr, 32'd0);
        check({name, "_di"}, mem_di, 32'd0);
        check({name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, 32'd0);
        check({name, "_done"}, {31'd0, load_done}, 32'd0);
        check({name, "_err"}, {31'd0, load_err}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_values("reset");
        model_state = 0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
    endtask

    initial begin
        bq_t good, bad_cs, oversize, framing, noise_empty, partial, after_done;
        int  w0;

        good        = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        bad_cs      = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                        8'h93, 8'h00, 8'h10, 8'h00, 8'hB7};
        oversize    = '{8'hA5, 8'h01, 8'h10, 8'h00, 8'h00};
        framing     = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00};
        noise_empty = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        partial     = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93};
        after_done  = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00};

        wait_clks(2);
        check_reset_values("por");
        rst_n = 1'b1;
        wait_clks(4);

        // Good image, then a further sync that must be ignored once done
        send_stream("good", good, -1, 1'b0);
        check("good_write_count", 32'(n_writes), 32'd2);
        check("good_last_addr", dut_last_addr, 32'h0000_0004);
        check("good_last_data", dut_last_data, 32'h0010_0093);
        check("good_cpu_released", {31'd0, cpu_rst_n}, 32'd1);
        send_stream("ignored_after_done", after_done, -1, 1'b0);
        check("ignored_after_done_writes", 32'(n_writes), 32'd2);

        do_reset();
        send_stream("bad_csum", bad_cs, -1, 1'b0);
        check("bad_csum_err_literal", {31'd0, load_err}, 32'd1);
        send_stream("resend", good, -1, 1'b1);

        do_reset();
        w0 = n_writes;
        send_stream("oversize", oversize, -1, 1'b0);
        check("oversize_no_write", 32'(n_writes - w0), 32'd0);

        w0 = n_writes;
        send_stream("framing", framing, 7, 1'b0);
        check("framing_no_write", 32'(n_writes - w0), 32'd0);
        check("framing_err_literal", {31'd0, load_err}, 32'd1);

        do_reset();
        w0 = n_writes;
        send_stream("noise_empty", noise_empty, -1, 1'b0);
        check("noise_empty_no_write", 32'(n_writes - w0), 32'd0);
        check("noise_empty_done_literal", {31'd0, load_done}, 32'd1);

        do_reset();
        send_stream("partial", partial, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_data_reset");
        model_state = 0;
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(3);
        w0 = n_writes;
        send_stream("fresh", good, -1, 1'b0);
        check("fresh_write_count", 32'(n_writes - w0), 32'd2);
        check("fresh_last_addr", dut_last_addr, 32'h0000_0004);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
